axi_ram_rd_sched: RTL and testbench

//  Round-robin read scheduler sharing one AXI4 read channel (AR/R) of an axi_ram between NUM_CLIENTS requesters.

---
 rtl/axi_ram_rd_sched.sv | 124 ++++++++++++
 tb/tb_axi_ram_rd_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_rd_sched.sv
// axi_ram_rd_sched: round-robin scheduler sharing one AXI4 read channel among NUM_CLIENTS requesters.
// Optional sticky response checking is enabled by defining AXI_RAM_RD_SCHED_CHECK_EN.
module axi_ram_rd_sched #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 8,
    localparam int CL_W       = $clog2(NUM_CLIENTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS-1:0]        req_valid,
    output logic [NUM_CLIENTS-1:0]        req_ready,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CLIENTS*8-1:0]      req_len,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [CL_W-1:0]               resp_client,
    output logic                          resp_last,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic                          resp_err,
    output logic [ID_WIDTH-1:0]           m_axi_arid,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [ID_WIDTH-1:0]           m_axi_rid,
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t                  state_q, state_d;
    logic [CL_W-1:0]         rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic                    found, r_hs;
    logic [CL_W:0]           idx;
    // Search downwards so the lowest offset from rr_ptr is the one left standing.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr_q} + (CL_W+1)'(i);
            if (idx >= (CL_W+1)'(NUM_CLIENTS)) idx = idx - (CL_W+1)'(NUM_CLIENTS);
            if (req_valid[idx[CL_W-1:0]]) begin
                pick  = idx[CL_W-1:0];
                found = 1'b1;
            end
        end
    end
    assign r_hs = (state_q == DATA) && m_axi_rvalid && resp_ready;
    // Next-state logic: grant in IDLE, hold AR in ADDR, pass beats through in DATA.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        len_d     = len_q;
        req_ready = '0;
        case (state_q)
            IDLE: if (found) begin
                req_ready = NUM_CLIENTS'(1) << pick;
                grant_d   = pick;
                addr_d    = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                len_d     = req_len[pick*8 +: 8];
                state_d   = ADDR;
            end
            ADDR: if (m_axi_arready) state_d = DATA;
            DATA: if (r_hs && m_axi_rlast) begin
                rr_ptr_d = (grant_q == CL_W'(NUM_CLIENTS - 1)) ? '0 : grant_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // State and latched request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
        end
    end
    assign m_axi_arid    = ID_WIDTH'(grant_q);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = 3'($clog2(STRB_WIDTH));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state_q == ADDR);
    assign m_axi_rready  = (state_q == DATA) && resp_ready;
    assign resp_valid    = (state_q == DATA) && m_axi_rvalid;
    assign resp_data     = m_axi_rdata;
    assign resp_last     = m_axi_rlast;
    assign resp_client   = grant_q;
`ifdef AXI_RAM_RD_SCHED_CHECK_EN
    logic err_q, err_d;
    assign err_d = err_q | (r_hs && (m_axi_rid != ID_WIDTH'(grant_q) || m_axi_rresp != 2'b00));
    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign resp_err = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{m_axi_rid, m_axi_rresp};
    assign resp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_axi_ram_rd_sched.sv
// tb_axi_ram_rd_sched: scoreboard bench with an AXI RAM slave model for axi_ram_rd_sched.
module tb_axi_ram_rd_sched;
    localparam int N = 4, DW = 32, AW = 16, IW = 8, CW = 2;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [N-1:0] req_valid, req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*8-1:0] req_len;
    logic [DW-1:0] resp_data;
    logic [CW-1:0] resp_client;
    logic resp_last, resp_valid, resp_ready, resp_err;
    logic [IW-1:0] m_axi_arid, m_axi_rid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0] m_axi_arlen;
    logic [2:0] m_axi_arsize;
    logic [1:0] m_axi_arburst, m_axi_rresp;
    logic m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [DW-1:0] m_axi_rdata;

    axi_ram_rd_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .resp_data(resp_data),
        .resp_client(resp_client), .resp_last(resp_last), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_err(resp_err), .m_axi_arid(m_axi_arid),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // RAM slave model: one burst at a time, beat data derived from the beat address.
    logic r_act = 1'b0, ar_block = 1'b0;
    logic [AW-1:0] r_addr = '0;
    logic [7:0] r_left = '0;
    logic [IW-1:0] r_id = '0, rid_xor = '0;
    assign m_axi_arready = !ar_block;
    assign m_axi_rvalid  = r_act;
    assign m_axi_rdata   = {~r_addr, r_addr};
    assign m_axi_rlast   = (r_left == 8'd0);
    assign m_axi_rid     = r_id ^ rid_xor;
    assign m_axi_rresp   = 2'b00;
    always @(posedge clk) begin
        if (rst) r_act <= 1'b0;
        else if (m_axi_arvalid && m_axi_arready) begin
            r_act  <= 1'b1;
            r_addr <= m_axi_araddr;
            r_left <= m_axi_arlen;
            r_id   <= m_axi_arid;
        end else if (r_act && m_axi_rready) begin
            if (r_left == 8'd0) r_act <= 1'b0;
            else begin
                r_addr <= r_addr + AW'(4);
                r_left <= r_left - 8'd1;
            end
        end
    end

    typedef struct { logic [DW-1:0] d; logic [CW-1:0] c; logic l; } beat_t;
    typedef struct { logic [CW-1:0] c; logic [AW-1:0] a; logic [7:0] l; } ar_t;
    beat_t exp_q[$];
    ar_t ar_q[$];
    int grant_log[$];
    int cnt[N] = '{default: 0};
    logic [AW-1:0] c_addr[N] = '{default: '0};
    logic [7:0] c_len[N] = '{default: '0};
    int n_chk = 0, n_err = 0, n_beats = 0;
    logic rr_toggle = 1'b0, mirror_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Client and response-ready driver, updated just after each rising edge.
    initial begin
        req_valid  = '0;
        req_addr   = '0;
        req_len    = '0;
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                req_valid[k]          = cnt[k] > 0;
                req_addr[k*AW +: AW]  = c_addr[k];
                req_len[k*8 +: 8]     = c_len[k];
            end
            resp_ready = rr_toggle ? ~resp_ready : 1'b1;
        end
    end

    // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        logic [AW-1:0] a;
        if (!rst) begin
            if (req_ready != '0)
                check("req_ready_onehot", {31'd0, $onehot(req_ready) && ((req_ready & ~req_valid) == '0)}, 1);
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    grant_log.push_back(k);
                    ar_q.push_back('{c: CW'(k), a: req_addr[k*AW +: AW], l: req_len[k*8 +: 8]});
                    for (int b = 0; b <= int'(req_len[k*8 +: 8]); b++) begin
                        a = req_addr[k*AW +: AW] + AW'(4 * b);
                        exp_q.push_back('{d: {~a, a}, c: CW'(k), l: (b == int'(req_len[k*8 +: 8]))});
                    end
                    cnt[k]    = cnt[k] - 1;
                    c_addr[k] = c_addr[k] + AW'(16'h40);
                end
            end
            if (m_axi_arvalid && m_axi_arready) begin
                if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
                else begin
                    ar_t e;
                    e = ar_q.pop_front();
                    check("arid", m_axi_arid, IW'(e.c));
                    check("araddr", m_axi_araddr, e.a);
                    check("arlen", m_axi_arlen, e.l);
                    check("arsize", m_axi_arsize, 3'd2);
                    check("arburst", m_axi_arburst, 2'd1);
                    check("ar_overlap", exp_q.size(), int'(m_axi_arlen) + 1);
                end
            end
            if (resp_valid && resp_ready) begin
                n_beats++;
                if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
                else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("resp_data", resp_data, e.d);
                    check("resp_client", resp_client, e.c);
                    check("resp_last", resp_last, e.l);
                end
            end
            if (mirror_en && m_axi_rvalid) check("rready_mirror", m_axi_rready, resp_ready);
        end
    end

    task automatic wait_drain();
        int t = 0;
        while ((cnt[0] + cnt[1] + cnt[2] + cnt[3] > 0 || exp_q.size() > 0 || ar_q.size() > 0) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 2000) check("drain_timeout", t, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        ar_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int b0, t;
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_err", resp_err, 0);
        // single client, 4-beat burst
        c_addr[2] = 16'h0100; c_len[2] = 8'd3; b0 = n_beats; cnt[2] = 1;
        wait_drain();
        check("t1_beats", n_beats - b0, 4);
        do_reset();
        // all clients continuously requesting
        grant_log.delete();
        for (int k = 0; k < N; k++) begin
            c_addr[k] = AW'(16'h1000 * (k + 1));
            c_len[k]  = 8'd1;
        end
        cnt[0] = 2; cnt[1] = 2; cnt[2] = 1; cnt[3] = 1;
        wait_drain();
        check("t2_grants", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) check("t2_order", grant_log[i], exp_order[i]);
        // toggled resp_ready during an 8-beat burst
        rr_toggle = 1'b1; mirror_en = 1'b1;
        c_addr[0] = 16'h0800; c_len[0] = 8'd7; b0 = n_beats; cnt[0] = 1;
        wait_drain();
        rr_toggle = 1'b0; mirror_en = 1'b0;
        check("t3_beats", n_beats - b0, 8);
        // address channel stalled for five cycles
        ar_block = 1'b1;
        c_addr[1] = 16'h2000; c_len[1] = 8'd2; cnt[1] = 1;
        c_addr[0] = 16'h3000; c_len[0] = 8'd0; cnt[0] = 1;
        t = 0;
        while (!m_axi_arvalid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("t4_arvalid_timeout", t, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_arvalid_held", m_axi_arvalid, 1);
            check("t4_araddr_stable", m_axi_araddr, 16'h2000);
            check("t4_arlen_stable", m_axi_arlen, 2);
            check("t4_no_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1 ar_block = 1'b0;
        wait_drain();
        // reset in the middle of a burst
        c_addr[3] = 16'h4000; c_len[3] = 8'd7; b0 = n_beats; cnt[3] = 1;
        t = 0;
        while (n_beats < b0 + 2 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (t >= 200) check("t5_beat_timeout", t, 0);
        #1 rst = 1'b1;
        exp_q.delete();
        ar_q.delete();
        for (int k = 0; k < N; k++) cnt[k] = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_arvalid", m_axi_arvalid, 0);
        check("t5_resp_valid", resp_valid, 0);
        check("t5_rready", m_axi_rready, 0);
        grant_log.delete();
        c_addr[1] = 16'h5000; c_len[1] = 8'd0; cnt[1] = 1;
        c_addr[3] = 16'h6000; c_len[3] = 8'd0; cnt[3] = 1;
        wait_drain();
        check("t5_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("t5_first", grant_log[0], 1);
            check("t5_second", grant_log[1], 3);
        end
        // wrong read ID while client 1 owns the channel
        check("t6_err_before", resp_err, 0);
        rid_xor = 8'h04;
        c_addr[1] = 16'h7000; c_len[1] = 8'd1; cnt[1] = 1;
        wait_drain();
        rid_xor = 8'h00;
`ifdef AXI_RAM_RD_SCHED_CHECK_EN
        check("t6_err_set", resp_err, 1);
`else
        check("t6_err_tied", resp_err, 0);
`endif
        do_reset();
        @(negedge clk);
        check("t6_err_cleared", resp_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
